// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver with scan-code FIFO and a DATA/STATUS register pair.
// Frames are sampled on synchronised keyboard-clock falling edges.
module ps2_keyboard #(
    parameter int CLK_FREQ   = 25000000,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic       rd,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       irq
);

    localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW        = AW + 1;
    localparam int TO_CYCLES = CLK_FREQ / 1000000 * TIMEOUT_US;
    localparam int TW        = $clog2(TO_CYCLES + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TO_CYCLES);
    localparam logic [TW-1:0] TO_ONE   = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic           clk_s1, clk_s2, clk_s3;
    logic           dat_s1, dat_s2;
    logic           fall;

    state_t         state, state_nxt;
    logic [2:0]     bitcnt;
    logic [7:0]     shreg;
    logic           par_bit;
    logic [TW-1:0]  to_cnt;
    logic           timeout;
    logic           push;
    logic           frame_err;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           ovf, err;
    logic           empty, full;
    logic           flush, w1c, pop_req;
    logic           do_push, do_pop, ovf_set;

    logic           unused;
    assign unused = &{1'b0, addr[7:1], data_in[7:4], data_in[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall    = clk_s3 & ~clk_s2;
    assign timeout = (state != S_IDLE) && (to_cnt == TO_LIMIT);

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        frame_err = 1'b0;
        if (fall) begin
            unique case (state)
                S_IDLE:   if (!dat_s2) state_nxt = S_DATA;
                S_DATA:   if (bitcnt == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP: begin
                    // Odd parity across data and parity bit, stop must be 1.
                    if (dat_s2 && (^{shreg, par_bit}))
                        push = 1'b1;
                    else
                        frame_err = 1'b1;
                    state_nxt = S_IDLE;
                end
            endcase
        end else if (timeout) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bitcnt  <= 3'd0;
            shreg   <= 8'h00;
            par_bit <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (fall && state == S_IDLE)
                bitcnt <= 3'd0;
            if (fall && state == S_DATA) begin
                shreg  <= {dat_s2, shreg[7:1]};
                bitcnt <= bitcnt + 3'd1;
            end
            if (fall && state == S_PARITY)
                par_bit <= dat_s2;
            if (fall || state == S_IDLE)
                to_cnt <= '0;
            else if (to_cnt != TO_LIMIT)
                to_cnt <= to_cnt + TO_ONE;
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign flush   = cs & we & ~addr[0];
    assign w1c     = cs & we & addr[0];
    assign pop_req = cs & rd & ~addr[0];

    // A pop in the same cycle frees the slot for a push into a full FIFO.
    assign do_pop  = pop_req & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign ovf_set = push & ~flush & full & ~do_pop;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)
                    rd_ptr <= rd_ptr + AW'(1);
                if (do_push && !do_pop)
                    count <= count + CNT_ONE;
                else if (do_pop && !do_push)
                    count <= count - CNT_ONE;
            end
            ovf <= ovf_set | (ovf & ~(w1c & data_in[2]));
            err <= frame_err | (err & ~(w1c & data_in[3]));
        end
    end

    always_comb begin
        data_out = 8'h00;
        if (addr[0])
            data_out = {4'b0000, err, ovf, full, ~empty};
        else if (!empty)
            data_out = mem[rd_ptr];
    end

    assign irq = ~empty;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed and randomized PS/2 frames checked against a queue-based model.
`timescale 1ns/1ps
module tb_ps2_keyboard;

    localparam int HALF  = 20;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic       we;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       ps2_clk;
    logic       ps2_data;
    logic       irq;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic       m_ovf;
    logic       m_err;

    ps2_keyboard #(
        .CLK_FREQ  (1000000),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_US(2000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .we      (we),
        .rd      (rd),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .irq     (irq)
    );

    // 1 MHz system clock: 40 cycles per PS/2 bit gives 40 us between falls.
    always #500 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {4'b0000, m_err, m_ovf, mq.size() == DEPTH, mq.size() != 0};
    endfunction

    task automatic m_push(input logic [7:0] b);
        if (mq.size() >= DEPTH)
            m_ovf = 1'b1;
        else
            mq.push_back(b);
    endtask

    task automatic chk_status(input string tag);
        addr = 8'h01;
        #1;
        chk(tag, data_out, m_status());
        chk({tag, "_irq"}, {7'd0, irq}, {7'd0, mq.size() != 0});
    endtask

    task automatic rd_data(input string tag);
        logic [7:0] exp;
        addr = 8'h00;
        #1;
        exp = (mq.size() != 0) ? mq[0] : 8'h00;
        chk(tag, data_out, exp);
        rd = 1'b1;
        cyc(1);
        rd = 1'b0;
        if (mq.size() != 0)
            void'(mq.pop_front());
    endtask

    task automatic wr_reg(input logic a0, input logic [7:0] v);
        addr    = {7'd0, a0};
        data_in = v;
        we      = 1'b1;
        cyc(1);
        we = 1'b0;
        if (a0) begin
            if (v[2]) m_ovf = 1'b0;
            if (v[3]) m_err = 1'b0;
        end else begin
            mq.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic bad_stop, input logic pop_at_stop);
        logic [10:0] f;
        logic        p;
        p = (~^b) ^ bad_par;
        f = {~bad_stop, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            if (i == 10 && pop_at_stop) begin
                // Strobe rd on the cycle the stop-bit fall is acted on.
                cyc(2);
                addr = 8'h00;
                rd   = 1'b1;
                #1;
                chk("pop_with_push_head", data_out, mq[0]);
                void'(mq.pop_front());
                cyc(1);
                rd = 1'b0;
                cyc(HALF - 3);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        cyc(HALF);
        if (!bad_par && !bad_stop)
            m_push(b);
        else
            m_err = 1'b1;
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            cyc(HALF);
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    initial begin
        rst      = 1'b1;
        cs       = 1'b1;
        we       = 1'b0;
        rd       = 1'b0;
        addr     = 8'h00;
        data_in  = 8'h00;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        m_ovf    = 1'b0;
        m_err    = 1'b0;
        cyc(3);
        chk("reset_data", data_out, 8'h00);
        chk_status("reset_status");
        rst = 1'b0;
        cyc(5);

        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        chk_status("t1_status");
        rd_data("t1_data");
        chk_status("t1_after_pop");

        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        chk_status("t2_parity_err");
        wr_reg(1'b1, 8'h08);
        chk_status("t2_cleared");

        for (int i = 1; i <= 17; i++)
            send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        chk_status("t3_full_ovf");
        for (int i = 0; i < 16; i++)
            rd_data("t3_drain");
        chk_status("t3_after_drain");
        wr_reg(1'b1, 8'h04);

        send_partial(5);
        cyc(2500);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        chk_status("t4_timeout");
        rd_data("t4_data");

        for (int i = 0; i < 16; i++)
            send_frame(8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        chk_status("t5_prefill");
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
        chk_status("t5_full_no_ovf");
        for (int i = 0; i < 16; i++)
            rd_data("t5_drain");
        chk_status("t5_empty");

        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        send_partial(6);
        #3;
        rst  = 1'b1;
        addr = 8'h00;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
        chk("t6_rst_data", data_out, 8'h00);
        chk_status("t6_rst_status");
        cyc(2);
        rst = 1'b0;
        cyc(2);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        chk_status("t6_status");
        rd_data("t6_data");

        for (int it = 0; it < 24; it++) begin
            int nrd;
            send_frame(8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 4) == 0),
                       1'($urandom_range(0, 7) == 0), 1'b0);
            nrd = $urandom_range(0, 2);
            for (int r = 0; r < nrd; r++)
                rd_data("rand_data");
            if ($urandom_range(0, 5) == 0)
                wr_reg(1'b1, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 11) == 0)
                wr_reg(1'b0, 8'($urandom_range(0, 255)));
            chk_status("rand_status");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
PS/2 keyboard receiver and bus peripheral occupying the ps2_cs region ($C0xx PS/2 window) of the SoC address map. It feeds the CPU read-data multiplexer alongside the UART and LCD. The block synchronises the keyboard clock and data lines, deframes 11-bit PS/2 frames, and checks parity and stop bits. Good scan codes go into a FIFO that the 6502 drains through a two-register interface.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz.
FIFO_DEPTH, 16, scan-code FIFO entries; must be a power of 2, minimum 2.
TIMEOUT_US, 2000, maximum gap between keyboard clock falling edges within a frame before the frame is abandoned.

Ports:
clk  input  1  system clock (25 MHz).
rst  input  1  asynchronous, active-high reset.
cs  input  1  chip select from the address decoder.
we  input  1  write strobe, single cycle, already qualified with cs.
rd  input  1  read strobe, single cycle, already qualified with cs; pops the FIFO on a DATA read.
addr  input  8  register offset; only addr[0] is decoded.
data_in  input  8  CPU write data.
data_out  output  8  register read data, combinational from addr and state.
ps2_clk  input  1  raw keyboard clock pin (open-drain, idle high).
ps2_data  input  1  raw keyboard data pin (idle high).
irq  output  1  level interrupt request; equals data_avail.

Behaviour:
- Reset is asynchronous and active-high. All flops clear: FIFO empty, pointers 0, count 0, flags 0, receiver in IDLE, synchronisers set to 1. Outputs at reset: data_out=$00 for the DATA register, $00 for STATUS, irq=0.
- Input conditioning:
  - 2-FF synchroniser on each of ps2_clk and ps2_data, plus a third flop on clk.
  - fall = (sync_clk_prev==1 && sync_clk==0).
  - All receiver actions happen only on cycles where fall=1.
- Receiver FSM, LSB first:
  - IDLE: on fall with data=0 (start bit), go to DATA, bitcnt=0. On fall with data=1, stay in IDLE (glitch).
  - DATA: on fall, shift the data bit into shreg[7] (right shift) and increment bitcnt. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, the frame is good if the stop bit is 1 and ^{shreg,parity}==1 (odd parity).
    - Good frame: push shreg.
    - Bad frame: set err sticky and discard.
    - Either way, return to IDLE.
- Timeout:
  - TO_CYCLES = CLK_FREQ/1000000*TIMEOUT_US, which is 50000 at the defaults.
  - The counter clears on every fall and whenever the FSM is in IDLE.
  - In a non-IDLE state, reaching TO_CYCLES forces IDLE silently: no push, no flag.
- Push latency: the byte is visible in DATA and data_avail=1 on the cycle after the stop-bit fall.
- Registers:
  - addr[0]=0 DATA read: FIFO head byte, or $00 if empty.
  - addr[0]=1 STATUS read: bit0 data_avail (count!=0), bit1 full (count==FIFO_DEPTH), bit2 overflow sticky, bit3 err sticky (parity or stop error), bits7:4 = 0.
  - rd with addr[0]=0: pop one entry if not empty. Pop on empty has no effect. rd of STATUS has no side effect.
  - we with addr[0]=0: flush the FIFO (pointers and count cleared). The data value is ignored.
  - we with addr[0]=1: write-1-to-clear; data_in[2] clears overflow, data_in[3] clears err. Other bits are ignored.
- FIFO boundaries:
  - Push when full: byte dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle: both occur, count unchanged. When full, the pop frees the slot and the push is accepted with no overflow.
  - Push and pop on empty in the same cycle: the push occurs, the pop is ignored, count becomes 1.
  - Flush in the same cycle as a push: flush wins and the byte is discarded.
  - Sticky set and W1C in the same cycle: set wins.
  - Pointers wrap modulo FIFO_DEPTH. The count register is log2(FIFO_DEPTH)+1 bits wide.
- Reset asserted mid-frame abandons the frame. After release, the receiver waits in IDLE for the next start bit. A partial frame then times out or is resynchronised by the next start bit.

Test Plan:
1. Bench drives frame $1C (start 0, bits 00111000 LSB first, parity 0, stop 1), with fall edges every 40 us. Expect: STATUS=$01, irq=1, DATA read returns $1C. After the rd pop, STATUS=$00 and irq=0.
2. Frame $1C sent with parity 1. Expect: no push, STATUS=$08. Write $08 to STATUS, then STATUS=$00.
3. 17 good frames $01..$11 sent with no reads. Expect: STATUS=$07 after the 17th. 16 DATA reads return $01..$10 in order, then STATUS=$04.
4. 4 data bits sent, then the clock is held high for 2.5 ms, then a full $F0 frame. Expect: only $F0 is in the FIFO, and STATUS bit3=0.
5. FIFO holds 16 entries; a DATA rd is issued on the same clk cycle as the stop-bit push of $AA. Expect: count stays 16, overflow=0, and the last entry is $AA.
6. rst is pulsed asynchronously, between clock edges, after 5 bits of a frame. Expect: all outputs are $00/0 immediately. A following full $5A frame is received correctly.
